// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher: 1-to-4 round-robin lane dispatcher with a one-entry
// output register. Each accepted word is steered to the next enabled lane
// (rotating from ptr) and held until that lane's consumer takes it.
// Optional feature macro: DEMUX_CNT_EN adds saturating per-lane dispatch
// counters (cnt) with a synchronous clear (cnt_clr).
module demux_rr_dispatcher #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       lane_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       sel
`ifdef DEMUX_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [4*CNT_W-1:0] cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       out_valid_q, out_valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       tgt;
  logic             out_fire;
  logic             in_fire;

  // Saturating increment used by the per-lane dispatch counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Handshake qualifiers; only the selected lane's ready matters.
  always_comb begin
    out_fire = (state_q == FULL) && out_ready[sel_q];
    in_ready = en && (lane_en != 4'b0000) && ((state_q == EMPTY) || out_fire);
    in_fire  = in_valid && in_ready;
  end

  // Round-robin target: first enabled lane scanning ptr, ptr+1, ... mod 4.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found = 1'b0;
    idx   = ptr_q;
    tgt   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && lane_en[idx]) begin
        tgt   = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state logic: capture on in_fire (also replaces a draining word),
  // otherwise empty out on out_fire, otherwise hold everything stable.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    if (in_fire) begin
      state_d     = FULL;
      out_valid_d = 4'b0001 << tgt;
      data_d      = in_data;
      sel_d       = tgt;
      ptr_d       = tgt + 2'd1;
    end else if (out_fire) begin
      state_d     = EMPTY;
      out_valid_d = 4'b0000;
    end
  end

  // State, held word and lane pointer; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_valid_q <= 4'b0000;
      data_q      <= '0;
      sel_q       <= 2'd0;
      ptr_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign sel       = sel_q;

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // Counter update: clear wins over a same-cycle dispatch.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr) begin
        cnt_d[i] = '0;
      end else if (out_fire && (sel_q == 2'(i))) begin
        cnt_d[i] = sat_inc(cnt_q[i]);
      end
    end
  end

  // Per-lane dispatch counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cnt_out
    assign cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Directed testbench for demux_rr_dispatcher. Counter checks are compiled
// only when DEMUX_CNT_EN is defined (counter width 2 in that build).
module tb_demux_rr_dispatcher;

  localparam int WIDTH = 8;
`ifdef DEMUX_CNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [3:0]       lane_en;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       sel;
`ifdef DEMUX_CNT_EN
  logic             cnt_clr;
  logic [4*CNT_W-1:0] cnt;
`endif

  int n_checks;
  int n_fail;

  demux_rr_dispatcher #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .lane_en   (lane_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel)
`ifdef DEMUX_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .cnt       (cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] v, input logic [1:0] s,
                           input logic [7:0] d);
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    check({tag, ".sel"},   64'(sel),       64'(s));
    check({tag, ".data"},  64'(out_data),  64'(d));
  endtask

  initial begin
    logic [1:0] exp_lane;
    logic [1:0] lanes_a [4];
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    en        = 1'b1;
    lane_en   = 4'b1111;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 4'b1111;
`ifdef DEMUX_CNT_EN
    cnt_clr   = 1'b0;
`endif

    // Reset state
    #2;
    check_out("reset", 4'b0000, 2'd0, 8'h00);
    check("reset.in_ready", 64'(in_ready), 64'd1);
    step();
    step();
    rst_n = 1'b1;
    step();
`ifdef DEMUX_CNT_EN
    check("reset.cnt", 64'(cnt), 64'd0);
`endif

    // Full-mask stream, all lanes ready: lanes 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(k);
      #1;
      check("stream.in_ready", 64'(in_ready), 64'd1);
      step();
      exp_lane = 2'(k % 4);
      check_out("stream", 4'b0001 << exp_lane, exp_lane, 8'h10 + 8'(k));
    end
    in_valid = 1'b0;
    step();
    check("stream.drain", 64'(out_valid), 64'd0);

    // Sparse mask 1010: lanes 1,3,1,3
    lanes_a[0] = 2'd1; lanes_a[1] = 2'd3; lanes_a[2] = 2'd1; lanes_a[3] = 2'd3;
    lane_en = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(k);
      step();
      check_out("mask1010", 4'b0001 << lanes_a[k], lanes_a[k], 8'hA0 + 8'(k));
    end
    in_valid = 1'b0;
    step();
    check("mask1010.drain", 64'(out_valid), 64'd0);

    // Word held on lane 2 while mask changes to 0001
    lane_en   = 4'b0100;
    out_ready = 4'b1011;
    in_valid  = 1'b1;
    in_data   = 8'hB0;
    step();
    check_out("retarget.cap", 4'b0100, 2'd2, 8'hB0);
    lane_en = 4'b0001;
    in_data = 8'hB1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("retarget.in_ready", 64'(in_ready), 64'd0);
      step();
      check_out("retarget.hold", 4'b0100, 2'd2, 8'hB0);
    end
    out_ready = 4'b1111;
    #1;
    check("retarget.in_ready_rel", 64'(in_ready), 64'd1);
    step();
    check_out("retarget.next", 4'b0001, 2'd0, 8'hB1);
    in_valid = 1'b0;
    step();
    check("retarget.drain", 64'(out_valid), 64'd0);

    // Back-pressure on selected lane for 5 cycles (ptr now 1)
    lane_en   = 4'b1111;
    out_ready = 4'b1101;
    in_valid  = 1'b1;
    in_data   = 8'hC0;
    step();
    check_out("bp.cap", 4'b0010, 2'd1, 8'hC0);
    in_data = 8'hC1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp.in_ready", 64'(in_ready), 64'd0);
      step();
      check_out("bp.hold", 4'b0010, 2'd1, 8'hC0);
    end
    out_ready = 4'b1111;
    #1;
    check("bp.in_ready_rel", 64'(in_ready), 64'd1);
    step();
    check_out("bp.next", 4'b0100, 2'd2, 8'hC1);
    in_valid = 1'b0;
    step();
    check("bp.drain", 64'(out_valid), 64'd0);

    // en=0 with a word held on lane 3 (ptr now 3)
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_data   = 8'hD0;
    step();
    check_out("en0.cap", 4'b1000, 2'd3, 8'hD0);
    en      = 1'b0;
    in_data = 8'hD1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("en0.in_ready", 64'(in_ready), 64'd0);
      step();
      check_out("en0.hold", 4'b1000, 2'd3, 8'hD0);
    end
    out_ready = 4'b1111;
    #1;
    check("en0.in_ready_drain", 64'(in_ready), 64'd0);
    step();
    check("en0.drained", 64'(out_valid), 64'd0);
    check("en0.in_ready_after", 64'(in_ready), 64'd0);
    step();
    check("en0.stay_empty", 64'(out_valid), 64'd0);

    // Reset mid-hold: E1 held on lane 1, then reset
    en       = 1'b1;
    in_data  = 8'hE0;
    step();
    check_out("rst.e0", 4'b0001, 2'd0, 8'hE0);
    in_data = 8'hE1;
    step();
    check_out("rst.e1", 4'b0010, 2'd1, 8'hE1);
    out_ready = 4'b0000;
    in_valid  = 1'b0;
    step();
    check_out("rst.hold", 4'b0010, 2'd1, 8'hE1);
    rst_n = 1'b0;
    #1;
    check_out("rst.async", 4'b0000, 2'd0, 8'h00);
    step();
    rst_n     = 1'b1;
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_data   = 8'hF0;
    step();
    check_out("rst.ptr0", 4'b0001, 2'd0, 8'hF0);
    in_valid = 1'b0;
    step();
    check("rst.drain", 64'(out_valid), 64'd0);

`ifdef DEMUX_CNT_EN
    // Counters: F0 dispatched once on lane 0 so far
    check("cnt.one", 64'(cnt), 64'h1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("cnt.rst", 64'(cnt), 64'd0);
    lane_en = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h50 + 8'(k);
      step();
    end
    in_valid = 1'b0;
    step();
    check("cnt.sat", 64'(cnt), 64'h3);
    in_valid = 1'b1;
    in_data  = 8'h60;
    step();
    cnt_clr = 1'b1;
    in_data = 8'h61;
    step();
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
    check("cnt.clr", 64'(cnt), 64'd0);
    check_out("cnt.clr_word", 4'b0001, 2'd0, 8'h61);
    step();
    check("cnt.after_clr", 64'(cnt), 64'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
